// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state type, the default operand width and the iteration counter width.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 8;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
// The master drives operands and out_ready; the slave is the divider itself.
interface restoring_divider_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               overflow;
  logic               div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// The partial remainder entering is always below the divisor, so the result fits in WIDTH bits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_diff;

  assign w_t    = {i_r, i_bit};
  assign w_diff = w_t - {1'b0, i_divisor};

  // Restore (keep T) when the trial subtraction would go negative.
  always_comb begin
    o_r_next = w_t[WIDTH-1:0];
    o_q_bit  = 1'b0;
    if (w_t >= {1'b0, i_divisor}) begin
      o_r_next = w_diff[WIDTH-1:0];
      o_q_bit  = 1'b1;
    end else begin
      o_r_next = w_t[WIDTH-1:0];
      o_q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides, all outputs registered.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  restoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_overflow;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_div_hi = bus.dividend[2*WIDTH-1:WIDTH];
  assign w_div_lo = bus.dividend[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r       (r_rem),
    .i_bit     (r_shift[WIDTH-1]),
    .i_divisor (r_div),
    .o_r_next  (w_r_next),
    .o_q_bit   (w_q_bit)
  );

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rem         <= {WIDTH{1'b0}};
      r_shift       <= {WIDTH{1'b0}};
      r_div         <= {WIDTH{1'b0}};
      r_q           <= {WIDTH{1'b0}};
      r_cnt         <= {CW{1'b0}};
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= {WIDTH{1'b0}};
      r_remainder   <= {WIDTH{1'b0}};
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_div      <= bus.divisor;
            r_in_ready <= 1'b0;
            if (bus.divisor == {WIDTH{1'b0}}) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= {WIDTH{1'b1}};
              r_remainder   <= w_div_lo;
              r_overflow    <= 1'b1;
              r_div_by_zero <= 1'b1;
            end else if (w_div_hi >= bus.divisor) begin
              // Quotient would need more than WIDTH bits; saturate.
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= {WIDTH{1'b1}};
              r_remainder   <= {WIDTH{1'b0}};
              r_overflow    <= 1'b1;
              r_div_by_zero <= 1'b0;
            end else begin
              r_state <= RUN;
              r_rem   <= w_div_hi;
              r_shift <= w_div_lo;
              r_q     <= {WIDTH{1'b0}};
              r_cnt   <= CW'(WIDTH);
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        RUN: begin
          r_rem   <= w_r_next;
          r_shift <= {r_shift[WIDTH-2:0], 1'b0};
          r_q     <= {r_q[WIDTH-2:0], w_q_bit};
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state       <= DONE;
            r_out_valid   <= 1'b1;
            r_quotient    <= {r_q[WIDTH-2:0], w_q_bit};
            r_remainder   <= w_r_next;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.overflow    = r_overflow;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with a behavioural reference model and result scoreboard.
module tb_restoring_divider;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  restoring_divider_if #(.WIDTH(8)) bus ();

  restoring_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] d, input logic [7:0] v);
    exp_t e;
    if (v == 8'd0) begin
      e.q = 8'hFF; e.r = d[7:0]; e.ovf = 1'b1; e.dbz = 1'b1;
    end else if (d[15:8] >= v) begin
      e.q = 8'hFF; e.r = 8'h00; e.ovf = 1'b1; e.dbz = 1'b0;
    end else begin
      e.q = 8'(d / 16'(v)); e.r = 8'(d % 16'(v)); e.ovf = 1'b0; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, then wait for and score the result.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [7:0] v,
                        input int exp_edges);
    int   n;
    exp_t e;
    bus.dividend = d;
    bus.divisor  = v;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 16'(bus.in_ready), 16'd1);
    tick();
    sb.push_back(model(d, v));
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 16'(n), 16'(exp_edges));
    chk({tag, "_inrdy_lo"}, 16'(bus.in_ready), 16'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, 16'(bus.quotient), 16'(e.q));
      chk({tag, "_r"}, 16'(bus.remainder), 16'(e.r));
      chk({tag, "_ovf"}, 16'(bus.overflow), 16'(e.ovf));
      chk({tag, "_dbz"}, 16'(bus.div_by_zero), 16'(e.dbz));
    end
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, 16'(bus.out_valid), 16'd0);
    chk({tag, "_inrdy_back"}, 16'(bus.in_ready), 16'd1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 8'd0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_inrdy", 16'(bus.in_ready), 16'd1);
    chk("rst_ovalid", 16'(bus.out_valid), 16'd0);
    chk("rst_q", 16'(bus.quotient), 16'd0);
    chk("rst_r", 16'(bus.remainder), 16'd0);
    chk("rst_flags", {14'd0, bus.overflow, bus.div_by_zero}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Normal result appears WIDTH edges after acceptance; exceptions in the very next cycle.
    run_op("norm", 16'd1000, 8'd7, 8);
    release_result("norm");
    run_op("dbz", 16'h1234, 8'h00, 0);
    release_result("dbz");
    run_op("ovf", 16'h0A00, 8'h0A, 0);
    release_result("ovf");
    run_op("bound", 16'hFEFF, 8'hFF, 8);
    release_result("bound");
    run_op("trip", 16'(16'd200 * 16'd53), 8'h35, 8);
    release_result("trip");

    // Backpressure: result held while new operands are waved at the block.
    run_op("bp", 16'd1000, 8'd7, 8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
      tick();
      chk("bp_hold_q", 16'(bus.quotient), 16'd142);
      chk("bp_hold_r", 16'(bus.remainder), 16'd6);
      chk("bp_hold_v", 16'(bus.out_valid), 16'd1);
      chk("bp_hold_rdy", 16'(bus.in_ready), 16'd0);
    end
    bus.in_valid = 1'b0;
    release_result("bp");
    chk("bp_after_q", 16'(bus.quotient), 16'd142);
    chk("bp_after_r", 16'(bus.remainder), 16'd6);

    // Reset during the 4th RUN cycle discards the operation.
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    sb.push_back(model(16'd1000, 8'd7));
    repeat (3) tick();
    chk("mid_running", 16'(bus.in_ready), 16'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk("mid_inrdy", 16'(bus.in_ready), 16'd1);
    chk("mid_ovalid", 16'(bus.out_valid), 16'd0);
    chk("mid_q", 16'(bus.quotient), 16'd0);
    chk("mid_r", 16'(bus.remainder), 16'd0);
    chk("mid_flags", {14'd0, bus.overflow, bus.div_by_zero}, 16'd0);
    run_op("post", 16'd255, 8'd16, 8);
    release_result("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
